// File: rtl/div32x16_seq.sv
// div32x16_seq: sequential unsigned divider, 32-bit dividend / 16-bit divisor.
// Radix-2 restoring division, one quotient bit per clock, 32 iterations.
// Handshake: a start seen in IDLE or DONE is accepted and latches a/b.
// busy is high for the 32 iteration cycles. done pulses for one cycle
// when q/r become valid, and q/r hold until the next accepted start.
// Optional feature macro: DIV32_DBZ_EN. When it is defined, the dbz port
// exists and a zero divisor completes in one cycle without entering RUN.
module div32x16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [15:0] r,
`ifdef DIV32_DBZ_EN
  output logic        dbz,
`endif
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] d_sh;
  logic [15:0] b_reg;
  logic [15:0] p;
  logic [31:0] q_sh;

  logic [16:0] t;
  logic        ge;
  logic [15:0] p_next;
  logic [31:0] q_next;

  // One restoring step. When t >= b, the true difference is below b,
  // so it fits in 16 bits and a 16-bit wrapping subtract is exact.
  always_comb begin
    t      = {p, d_sh[31]};
    ge     = (t >= {1'b0, b_reg});
    p_next = ge ? (t[15:0] - b_reg) : t[15:0];
    q_next = {q_sh[30:0], ge};
  end

  // Status outputs are decoded directly from the state register.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    fsm_state = state;
  end

  // Control FSM and datapath registers. Reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      d_sh  <= 32'd0;
      b_reg <= 16'd0;
      p     <= 16'd0;
      q_sh  <= 32'd0;
      q     <= 32'd0;
      r     <= 16'd0;
`ifdef DIV32_DBZ_EN
      dbz   <= 1'b0;
`endif
    end else begin
`ifdef DIV32_DBZ_EN
      dbz <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            d_sh  <= a;
            b_reg <= b;
            p     <= 16'd0;
            q_sh  <= 32'd0;
`ifdef DIV32_DBZ_EN
            if (b == 16'd0) begin
              // Zero divisor: report the result immediately and skip RUN.
              state <= DONE;
              cnt   <= 5'd0;
              q     <= 32'hFFFF_FFFF;
              r     <= a[15:0];
              dbz   <= 1'b1;
            end else begin
              state <= RUN;
              cnt   <= 5'd31;
            end
`else
            state <= RUN;
            cnt   <= 5'd31;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p    <= p_next;
          d_sh <= {d_sh[30:0], 1'b0};
          q_sh <= q_next;
          if (cnt == 5'd0) begin
            // Last iteration: q and r are registered here so they are visible while done is high.
            state <= DONE;
            q     <= q_next;
            r     <= p_next;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32x16_seq.sv
// tb_div32x16_seq: directed testbench for div32x16_seq.
// The optional macro DIV32_DBZ_EN selects the expected zero-divisor behaviour.
module tb_div32x16_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [15:0] b = 16'd0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [15:0] r;
  logic [1:0]  fsm_state;
`ifdef DIV32_DBZ_EN
  logic        dbz;
`endif

  int total = 0;
  int bad   = 0;

  div32x16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
`ifdef DIV32_DBZ_EN
    .dbz       (dbz),
`endif
    .fsm_state (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Advance one clock. Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one division from IDLE or DONE. Check the busy length, the done
  // pulse and the result. The task returns in the done cycle.
  // If glitch_at is nonzero, start is pulsed with junk operands during RUN.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [15:0] bv,
                        input logic [31:0] eq, input logic [15:0] er, input int glitch_at);
    int cnt;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = 16'($urandom);
    chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (glitch_at != 0 && cnt == glitch_at) begin
        start = 1'b1; a = 32'd1; b = 16'd1;
      end else begin
        start = 1'b0;
      end
      cnt++;
      tick();
    end
    start = 1'b0;
    chk({tag, "_latency"}, cnt, 32);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, {16'd0, r}, {16'd0, er});
`ifdef DIV32_DBZ_EN
    chk({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
`endif
  endtask

  // scoreboard: expected quotients/remainders for the random phase
  logic [31:0] exp_q[$];
  logic [15:0] exp_r[$];

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    int seen;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", {16'd0, r}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);

    // Basic division, then hold with start low
    do_div("basic", 32'd1000, 16'd7, 32'd142, 16'd6, 0);
    tick();
    chk("basic_done_pulse", {31'd0, done}, 32'd0);
    tick(); tick();
    chk("basic_hold_q", q, 32'd142);
    chk("basic_hold_r", {16'd0, r}, 32'd6);
    chk("basic_idle", {30'd0, fsm_state}, 32'd0);

    // Extremes
    do_div("max", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 0);
    tick();
    do_div("small", 32'd5, 16'd9, 32'd0, 16'd5, 0);
    tick();

    // Start during RUN is ignored
    do_div("glitch", 32'd1000, 16'd7, 32'd142, 16'd6, 5);
    // Back-to-back: start in the DONE cycle
    do_div("b2b", 32'd100, 16'd10, 32'd10, 16'd0, 0);
    tick();

    // Divide by zero
`ifdef DIV32_DBZ_EN
    a = 32'h1234_ABCD; b = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dbz_done", {31'd0, done}, 32'd1);
    chk("dbz_flag", {31'd0, dbz}, 32'd1);
    chk("dbz_busy", {31'd0, busy}, 32'd0);
    chk("dbz_q", q, 32'hFFFF_FFFF);
    chk("dbz_r", {16'd0, r}, 32'h0000_ABCD);
    tick();
    chk("dbz_clear", {31'd0, dbz}, 32'd0);
    chk("dbz_idle_busy", {31'd0, busy}, 32'd0);
`else
    do_div("dbz", 32'h1234_ABCD, 16'd0, 32'hFFFF_FFFF, 16'hABCD, 0);
    tick();
`endif

    // Reset held 2 cycles mid-RUN
    a = 32'd1000; b = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", {16'd0, r}, 32'd0);
    chk("mid_rst_state", {30'd0, fsm_state}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done || busy) seen++;
    end
    chk("mid_rst_no_done", seen, 0);

    // Random regression against a reference quotient/remainder
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = 16'($urandom_range(1, 65535));
      if (i % 3 == 0) rb = 16'($urandom_range(1, 15));
      exp_q.push_back(ra / {16'd0, rb});
      exp_r.push_back(16'(ra % {16'd0, rb}));
      do_div("rand", ra, rb, exp_q.pop_front(), exp_r.pop_front(), 0);
      if (i % 2 == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
